// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: I2S capture per line, per-channel frame delay, masked saturating sum.
// Sum is valid at cnt=NUM_CH+1 of frame n+1; serial output carries it in frame n+2; no backpressure.
module delay_sum_beamformer #(
  parameter int NUM_LINES   = 2,
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_CLKS   = 32,
  parameter int DEPTH       = 8,
  parameter int SHIFT       = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LINES-1:0]            sd_in,
  output logic                            ws_out,
  output logic                            sd_out,
  input  logic [2*NUM_LINES-1:0]          ch_mask,
  input  logic                            cfg_we,
  input  logic [$clog2(2*NUM_LINES):0]    cfg_addr,
  input  logic [$clog2(DEPTH)-1:0]        cfg_wdata,
  output logic [$clog2(DEPTH)-1:0]        cfg_rdata,
  output logic [SAMPLE_BITS-1:0]          sum_data,
  output logic                            sum_valid,
  output logic                            sum_sat
);
  localparam int NUM_CH = 2 * NUM_LINES;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int DW     = $clog2(DEPTH);
  localparam int CW     = $clog2(2 * SLOT_CLKS);
  localparam int BW     = $clog2(SAMPLE_BITS);
  localparam int AW     = SAMPLE_BITS + CH_W;
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** (SAMPLE_BITS - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_nx;

  logic [CW-1:0]          cnt, p;
  logic                   in_win, strobe;
  logic [SAMPLE_BITS-1:0] sh_l [NUM_LINES];
  logic [SAMPLE_BITS-1:0] sh_r [NUM_LINES];
  logic [SAMPLE_BITS-1:0] fbuf [DEPTH][NUM_CH];
  logic [DW-1:0]          delay [NUM_CH];
  logic [DW-1:0]          dsnap [NUM_CH];
  logic [DW-1:0]          wr_ptr, rd_idx;
  logic [SAMPLE_BITS-1:0] hold, rd_sample, sat_val;
  logic [CH_W-1:0]        ch, cfg_idx;
  logic [BW-1:0]          bit_idx;
  logic                   cfg_ok, sat_hi, sat_lo;
  logic signed [AW-1:0]   acc, term, shf;

  assign ws_out  = cnt >= CW'(SLOT_CLKS);
  assign p       = ws_out ? cnt - CW'(SLOT_CLKS) : cnt;
  assign in_win  = (p != '0) && (p <= CW'(SAMPLE_BITS));
  assign strobe  = cnt == CW'(2 * SLOT_CLKS - 1);
  assign bit_idx = BW'(CW'(SAMPLE_BITS) - p);
  assign sd_out  = in_win ? hold[bit_idx] : 1'b0;

  // wr_ptr has already advanced past the newest entry while ACC runs
  assign ch        = CH_W'(cnt);
  assign rd_idx    = wr_ptr - DW'(1) - dsnap[ch];
  assign rd_sample = fbuf[rd_idx][ch];
  assign term      = ch_mask[ch] ? $signed({{CH_W{rd_sample[SAMPLE_BITS-1]}}, rd_sample}) : '0;

  assign shf     = acc >>> SHIFT;
  assign sat_hi  = shf > MAXV;
  assign sat_lo  = shf < MINV;
  assign sat_val = sat_hi ? SAMPLE_BITS'(MAXV) :
                   sat_lo ? SAMPLE_BITS'(MINV) : shf[SAMPLE_BITS-1:0];

  assign cfg_ok  = cfg_addr < (CH_W + 1)'(NUM_CH);
  assign cfg_idx = cfg_addr[CH_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (strobe) state_nx = ACC;
      ACC:     if (cnt == CW'(NUM_CH - 1)) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      wr_ptr    <= '0;
      hold      <= '0;
      acc       <= '0;
      sum_data  <= '0;
      sum_valid <= 1'b0;
      sum_sat   <= 1'b0;
      cfg_rdata <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        sh_l[i] <= '0;
        sh_r[i] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        delay[c] <= '0;
        dsnap[c] <= '0;
      end
      for (int d = 0; d < DEPTH; d++)
        for (int c = 0; c < NUM_CH; c++)
          fbuf[d][c] <= '0;
    end else begin
      cnt       <= strobe ? '0 : cnt + CW'(1);
      sum_valid <= 1'b0;

      // one-bit I2S delay: slot bit 0 and bits past SAMPLE_BITS are ignored
      for (int i = 0; i < NUM_LINES; i++) begin
        if (in_win) begin
          if (ws_out) sh_r[i] <= {sh_r[i][SAMPLE_BITS-2:0], sd_in[i]};
          else        sh_l[i] <= {sh_l[i][SAMPLE_BITS-2:0], sd_in[i]};
        end
      end

      if (strobe) begin
        for (int i = 0; i < NUM_LINES; i++) begin
          fbuf[wr_ptr][2*i]   <= sh_l[i];
          fbuf[wr_ptr][2*i+1] <= sh_r[i];
        end
        wr_ptr <= wr_ptr + DW'(1);
        dsnap  <= delay;
        hold   <= sum_data;
        acc    <= '0;
      end

      if (state == ACC) acc <= acc + term;

      if (state == OUT) begin
        sum_data  <= sat_val;
        sum_sat   <= sat_hi | sat_lo;
        sum_valid <= 1'b1;
      end

      if (cfg_we && cfg_ok) delay[cfg_idx] <= cfg_wdata;
      cfg_rdata <= cfg_ok ? delay[cfg_idx] : '0;
    end
  end

endmodule
